// File: rtl/gray_pkg.sv
// Shared helpers for binary/Gray conversion; pure functions, no state.
// Latency: combinational only.
// Backpressure: not applicable (no handshake).
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  // Operates on a zero-extended 32-bit value; callers truncate back to their
  // width. Zero upper bits never leak into the lower Gray bits.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the result unchanged.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_W_MAX - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [GRAY_W_MAX-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Gray-to-binary decoder: bin[MSB] = gray[MSB], bin[i] = bin[i+1] ^ gray[i].
// Latency: combinational.
// Backpressure: none.
// Ports: gray (WIDTH) in, binary (WIDTH) out.
module gray2bin_dec #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  // Running XOR held in a scalar so the vector output never feeds itself.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    binary = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc       = acc ^ gray[i];
      binary[i] = acc;
    end
  end

endmodule

// File: rtl/bin_gray.sv
// Binary-to-Gray converter with a registered copy and round-trip/step checkers.
// Latency: gray is combinational; gray_q/out_valid 1 cycle; rt_err 2 cycles.
// Backpressure: none; every cycle with in_valid high is accepted.
// Ports: clk, rst_n (async, active low), binary/in_valid in;
//        gray (comb), gray_q/out_valid (registered), bin_rt (decoded gray_q),
//        rt_err/step_err (registered fault flags).
module bin_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] binary,
  input  logic             in_valid,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_rt,
  output logic             rt_err,
  output logic             step_err
);

  logic [WIDTH-1:0] bin_q;
  logic             prev_valid;
  logic [WIDTH-1:0] diff;
  logic             adjacent;
  logic             step_bad;

  assign gray = WIDTH'(bin2gray(32'(binary)));

  gray2bin_dec #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray  (gray_q),
    .binary(bin_rt)
  );

  // Modular difference makes all-ones <-> zero count as a unit step.
  assign diff     = binary - bin_q;
  assign adjacent = (diff == WIDTH'(1)) || (diff == {WIDTH{1'b1}});
  assign step_bad = (popcount(32'(gray ^ gray_q)) != 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      gray_q     <= '0;
      out_valid  <= 1'b0;
      prev_valid <= 1'b0;
      rt_err     <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      // Compares the currently presented gray_q against the binary it came from.
      rt_err <= out_valid && (bin_rt != bin_q);
      if (in_valid) begin
        bin_q      <= binary;
        gray_q     <= gray;
        out_valid  <= 1'b1;
        prev_valid <= 1'b1;
        step_err   <= prev_valid && adjacent && step_bad;
      end else begin
        out_valid <= 1'b0;
        step_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin_gray.sv
module tb_bin_gray;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       step;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic [3:0] binary4, gray4, gray_q4, bin_rt4;
  logic       in_valid4, out_valid4, rt_err4, step_err4;
  logic [7:0] binary8, gray8, gray_q8, bin_rt8;
  logic       in_valid8, out_valid8, rt_err8, step_err8;

  int n_pass;
  int n_total;

  exp_t q4[$];
  exp_t q8[$];
  logic [3:0] hold4;
  logic [7:0] hold8;
  logic       pv4, pv8;
  logic [3:0] prev4;
  logic [7:0] prev8;

  // Reflected 4-bit Gray sequence, written out as a table.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  bin_gray #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .binary(binary4), .in_valid(in_valid4),
    .gray(gray4), .gray_q(gray_q4), .out_valid(out_valid4), .bin_rt(bin_rt4),
    .rt_err(rt_err4), .step_err(step_err4)
  );

  bin_gray #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .binary(binary8), .in_valid(in_valid8),
    .gray(gray8), .gray_q(gray_q8), .out_valid(out_valid8), .bin_rt(bin_rt8),
    .rt_err(rt_err8), .step_err(step_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic exp_step(input int w, input logic pv,
                                    input logic [7:0] prev, input logic [7:0] cur,
                                    input logic [7:0] gprev, input logic [7:0] gcur);
    int mask, d;
    mask = (1 << w) - 1;
    d    = (int'(cur) - int'(prev)) & mask;
    return pv && (d == 1 || d == mask) && ($countones(gcur ^ gprev) != 1);
  endfunction

  task automatic drive4(input logic [3:0] v, input logic vld);
    exp_t e;
    @(posedge clk);
    #2;
    binary4   = v;
    in_valid4 = vld;
    #1 check("gray_comb4", gray4, gtab[v]);
    if (vld) begin
      e.bin  = 8'(v);
      e.gray = 8'(gtab[v]);
      e.step = exp_step(4, pv4, 8'(prev4), 8'(v), 8'(gtab[prev4]), 8'(gtab[v]));
      q4.push_back(e);
      pv4   = 1'b1;
      prev4 = v;
    end
  endtask

  task automatic drive8(input logic [7:0] v, input logic vld);
    exp_t e;
    logic [7:0] g, gp;
    g  = v ^ (v >> 1);
    gp = prev8 ^ (prev8 >> 1);
    @(posedge clk);
    #2;
    binary8   = v;
    in_valid8 = vld;
    #1 check("gray_comb8", gray8, g);
    if (vld) begin
      e.bin  = v;
      e.gray = g;
      e.step = exp_step(8, pv8, prev8, v, gp, g);
      q8.push_back(e);
      pv8   = 1'b1;
      prev8 = v;
    end
  endtask

  // Reset is asserted asynchronously, one time unit after a falling edge.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_gray_q4", gray_q4, 0);
    check("mid_rst_out_valid4", out_valid4, 0);
    check("mid_rst_step_err4", step_err4, 0);
    check("mid_rst_rt_err4", rt_err4, 0);
    check("mid_rst_gray_q8", gray_q8, 0);
    q4.delete();
    q8.delete();
    hold4 = '0;
    hold8 = '0;
    pv4   = 1'b0;
    pv8   = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    check("rt_err4", rt_err4, 0);
    if (out_valid4) begin
      if (q4.size() == 0) begin
        n_total++;
        $display("FAIL sb4_underflow: out_valid4 with no expected item (t=%0t)", $time);
      end else begin
        e = q4.pop_front();
        check("gray_q4", gray_q4, e.gray);
        check("bin_rt4", bin_rt4, e.bin);
        check("step_err4", step_err4, e.step);
        hold4 = e.gray[3:0];
      end
    end else begin
      check("hold_gray_q4", gray_q4, hold4);
      check("idle_step_err4", step_err4, 0);
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    check("rt_err8", rt_err8, 0);
    if (out_valid8) begin
      if (q8.size() == 0) begin
        n_total++;
        $display("FAIL sb8_underflow: out_valid8 with no expected item (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        check("gray_q8", gray_q8, e.gray);
        check("bin_rt8", bin_rt8, e.bin);
        check("step_err8", step_err8, e.step);
        hold8 = e.gray;
      end
    end else begin
      check("hold_gray_q8", gray_q8, hold8);
      check("idle_step_err8", step_err8, 0);
    end
  end

  initial begin
    logic [3:0] v4;
    logic [7:0] v8;
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    binary4   = '0;
    binary8   = '0;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    hold4 = '0; hold8 = '0;
    pv4   = 1'b0; pv8 = 1'b0;
    prev4 = '0; prev8 = '0;

    #1;
    check("rst_gray_q4", gray_q4, 0);
    check("rst_out_valid4", out_valid4, 0);
    check("rst_rt_err4", rt_err4, 0);
    check("rst_step_err4", step_err4, 0);
    check("rst_gray_q8", gray_q8, 0);
    check("rst_out_valid8", out_valid8, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // First accept after reset, then full count with wrap back to zero.
    drive4(4'b0101, 1'b1);
    for (int i = 0; i < 16; i++) drive4(4'(i), 1'b1);
    drive4(4'h0, 1'b1);
    drive4(4'hF, 1'b1);            // downward wrap 0 -> all-ones

    // Non-adjacent jump.
    drive4(4'b0011, 1'b1);
    drive4(4'b1000, 1'b1);

    // Hold: gray_q must keep 1111 while in_valid is low.
    drive4(4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) drive4(4'($urandom_range(0, 15)), 1'b0);

    // Random mix of unit steps and arbitrary jumps.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       v4 = prev4 + 4'd1;
        1:       v4 = prev4 - 4'd1;
        default: v4 = 4'($urandom_range(0, 15));
      endcase
      drive4(v4, $urandom_range(0, 3) != 0);
    end

    mid_reset();
    drive4(4'b0101, 1'b1);
    drive4(4'b0110, 1'b1);
    drive4(4'b0110, 1'b0);

    // Wider instance.
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 2))
        0:       v8 = prev8 + 8'd1;
        1:       v8 = prev8 - 8'd1;
        default: v8 = 8'($urandom_range(0, 255));
      endcase
      drive8(v8, $urandom_range(0, 3) != 0);
    end
    drive8(8'hFF, 1'b1);
    drive8(8'h00, 1'b1);
    drive8(8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb4_drained", q4.size(), 0);
    check("sb8_drained", q8.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
